// File: rtl/dmem_responder.sv
// Single-port byte/half/word data memory responder with a fixed IDLE->ACCESS->RESP
// handshake, alignment checking and success counters.
module dmem_responder #(
    parameter int DEPTH_WORDS = 32
) (
    input  logic                             clk,
    input  logic                             clr,
    input  logic                             req,
    input  logic                             we,
    input  logic [1:0]                       mode,
    input  logic [$clog2(DEPTH_WORDS)+1:0]   addr,
    input  logic [31:0]                      wdata,
    output logic                             ack,
    output logic                             err,
    output logic [31:0]                      rdata,
    output logic                             busy,
    output logic [31:0]                      rd_count,
    output logic [31:0]                      wr_count
);
    localparam int AW = $clog2(DEPTH_WORDS) + 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_we;
    logic [1:0]        r_mode;
    logic [AW-1:0]     r_addr;
    logic [31:0]       r_wdata;
    logic              r_ack;
    logic              r_err;
    logic [31:0]       r_rdata;
    logic [31:0]       r_rd_count;
    logic [31:0]       r_wr_count;
    logic [31:0]       r_mem [DEPTH_WORDS];
    logic              w_reject;
    logic [31:0]       w_word;

    function automatic logic f_reject(input logic [1:0] m, input logic [1:0] a);
        logic bad;
        case (m)
            2'b00:   bad = 1'b0;
            2'b01:   bad = a[0];
            2'b10:   bad = (a != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Merge right-aligned write data into only the addressed lanes.
    function automatic logic [31:0] f_merge(input logic [31:0] old, input logic [31:0] wd,
                                            input logic [1:0] m, input logic [1:0] a);
        logic [31:0] res;
        res = old;
        case (m)
            2'b00: begin
                case (a)
                    2'b00:   res[7:0]   = wd[7:0];
                    2'b01:   res[15:8]  = wd[7:0];
                    2'b10:   res[23:16] = wd[7:0];
                    default: res[31:24] = wd[7:0];
                endcase
            end
            2'b01: begin
                if (a[1]) res[31:16] = wd[15:0];
                else      res[15:0]  = wd[15:0];
            end
            2'b10:   res = wd;
            default: res = old;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] f_extract(input logic [31:0] word, input logic [1:0] m,
                                              input logic [1:0] a);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {a, 3'b000};
        case (m)
            2'b00:   res = {24'd0, sh[7:0]};
            2'b01:   res = {16'd0, sh[15:0]};
            2'b10:   res = word;
            default: res = 32'd0;
        endcase
        return res;
    endfunction

    assign w_reject = f_reject(r_mode, r_addr[1:0]);
    assign w_word   = r_mem[r_addr[AW-1:2]];

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (req) w_state_next = ACCESS;
                else     w_state_next = IDLE;
            end
            ACCESS:  w_state_next = RESP;
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // State, request capture, storage, response and counters.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state    <= IDLE;
            r_we       <= 1'b0;
            r_mode     <= 2'b00;
            r_addr     <= '0;
            r_wdata    <= 32'd0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_rdata    <= 32'd0;
            r_rd_count <= 32'd0;
            r_wr_count <= 32'd0;
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                r_mem[i] <= 32'd0;
            end
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: begin
                    if (req) begin
                        r_we    <= we;
                        r_mode  <= mode;
                        r_addr  <= addr;
                        r_wdata <= wdata;
                    end
                end
                ACCESS: begin
                    r_ack   <= 1'b1;
                    r_err   <= w_reject;
                    r_rdata <= (w_reject || r_we) ? 32'd0
                                                  : f_extract(w_word, r_mode, r_addr[1:0]);
                    if (!w_reject && r_we) begin
                        r_mem[r_addr[AW-1:2]] <= f_merge(w_word, r_wdata, r_mode, r_addr[1:0]);
                    end
                end
                RESP: begin
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                    r_rdata <= 32'd0;
                    if (!r_err) begin
                        if (r_we) r_wr_count <= r_wr_count + 32'd1;
                        else      r_rd_count <= r_rd_count + 32'd1;
                    end
                end
                default: begin
                    r_ack   <= 1'b0;
                    r_err   <= 1'b0;
                    r_rdata <= 32'd0;
                end
            endcase
        end
    end

    assign ack      = r_ack;
    assign err      = r_err;
    assign rdata    = r_rdata;
    assign busy     = (r_state != IDLE);
    assign rd_count = r_rd_count;
    assign wr_count = r_wr_count;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder with hand-computed expectations.
module tb_dmem_responder;
    logic        clk;
    logic        clr;
    logic        req;
    logic        we;
    logic [1:0]  mode;
    logic [6:0]  addr;
    logic [31:0] wdata;
    logic        ack;
    logic        err;
    logic [31:0] rdata;
    logic        busy;
    logic [31:0] rd_count;
    logic [31:0] wr_count;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_responder #(.DEPTH_WORDS(32)) dut (
        .clk      (clk),
        .clr      (clr),
        .req      (req),
        .we       (we),
        .mode     (mode),
        .addr     (addr),
        .wdata    (wdata),
        .ack      (ack),
        .err      (err),
        .rdata    (rdata),
        .busy     (busy),
        .rd_count (rd_count),
        .wr_count (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called #1 after a clock edge in IDLE; returns #1 after the edge leaving RESP.
    task automatic do_access(input string tag, input logic w, input logic [1:0] m,
                             input logic [6:0] a, input logic [31:0] d,
                             input logic exp_err, input logic [31:0] exp_rd);
        req = 1'b1; we = w; mode = m; addr = a; wdata = d;
        @(posedge clk); #1;
        req = 1'b0; we = ~w; mode = ~m; addr = ~a; wdata = ~d;
        check_eq({tag, " access ack"}, {31'd0, ack}, 32'd0);
        check_eq({tag, " access busy"}, {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        check_eq({tag, " resp ack"}, {31'd0, ack}, 32'd1);
        check_eq({tag, " resp err"}, {31'd0, err}, {31'd0, exp_err});
        if (!w || exp_err) check_eq({tag, " rdata"}, rdata, exp_rd);
        @(posedge clk); #1;
        check_eq({tag, " idle ack"}, {31'd0, ack}, 32'd0);
        check_eq({tag, " idle err"}, {31'd0, err}, 32'd0);
        check_eq({tag, " idle rdata"}, rdata, 32'd0);
        check_eq({tag, " idle busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        clr = 1'b0; req = 1'b0; we = 1'b0; mode = 2'b00; addr = 7'd0; wdata = 32'd0;
        #1;
        check_eq("rst ack", {31'd0, ack}, 32'd0);
        check_eq("rst err", {31'd0, err}, 32'd0);
        check_eq("rst busy", {31'd0, busy}, 32'd0);
        check_eq("rst rdata", rdata, 32'd0);
        check_eq("rst rd_count", rd_count, 32'd0);
        check_eq("rst wr_count", wr_count, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk); #1;

        // Word write/read round trip.
        do_access("wr word 08", 1'b1, 2'b10, 7'h08, 32'h1122_3344, 1'b0, 32'd0);
        do_access("rd word 08", 1'b0, 2'b10, 7'h08, 32'd0, 1'b0, 32'h1122_3344);
        check_eq("cnt wr a", wr_count, 32'd1);
        check_eq("cnt rd a", rd_count, 32'd1);

        // Sub-word lanes.
        do_access("wr byte 0B", 1'b1, 2'b00, 7'h0B, 32'h5555_55AA, 1'b0, 32'd0);
        do_access("rd word 08b", 1'b0, 2'b10, 7'h08, 32'd0, 1'b0, 32'hAA22_3344);
        do_access("rd half 0A", 1'b0, 2'b01, 7'h0A, 32'd0, 1'b0, 32'h0000_AA22);
        do_access("rd byte 09", 1'b0, 2'b00, 7'h09, 32'd0, 1'b0, 32'h0000_0033);
        check_eq("cnt wr b", wr_count, 32'd2);
        check_eq("cnt rd b", rd_count, 32'd4);

        // Rejected accesses leave storage and counters alone.
        do_access("rd word 05 bad", 1'b0, 2'b10, 7'h05, 32'd0, 1'b1, 32'd0);
        do_access("mode11 00 bad", 1'b0, 2'b11, 7'h00, 32'd0, 1'b1, 32'd0);
        do_access("wr mode11 bad", 1'b1, 2'b11, 7'h08, 32'hFFFF_FFFF, 1'b1, 32'd0);
        do_access("wr half 09 bad", 1'b1, 2'b01, 7'h09, 32'hFFFF_FFFF, 1'b1, 32'd0);
        check_eq("cnt wr c", wr_count, 32'd2);
        check_eq("cnt rd c", rd_count, 32'd4);
        do_access("rd word 08c", 1'b0, 2'b10, 7'h08, 32'd0, 1'b0, 32'hAA22_3344);

        // Extra req pulses while busy are ignored.
        req = 1'b1; we = 1'b1; mode = 2'b01; addr = 7'h0C; wdata = 32'h9999_5566;
        @(posedge clk); #1;
        check_eq("busy req access", {31'd0, busy}, 32'd1);
        @(posedge clk); #1;
        check_eq("busy req ack", {31'd0, ack}, 32'd1);
        @(posedge clk); #1;
        req = 1'b0;
        check_eq("busy req idle", {31'd0, busy}, 32'd0);
        repeat (2) begin
            @(posedge clk); #1;
            check_eq("busy req no ack", {31'd0, ack | busy}, 32'd0);
        end
        check_eq("cnt wr d", wr_count, 32'd3);
        check_eq("cnt rd d", rd_count, 32'd5);
        do_access("wr byte 0E", 1'b1, 2'b00, 7'h0E, 32'h0000_0077, 1'b0, 32'd0);
        do_access("rd word 0C", 1'b0, 2'b10, 7'h0C, 32'd0, 1'b0, 32'h0077_5566);
        do_access("rd half 0E", 1'b0, 2'b01, 7'h0E, 32'd0, 1'b0, 32'h0000_0077);
        check_eq("cnt wr e", wr_count, 32'd4);
        check_eq("cnt rd e", rd_count, 32'd7);

        // Reset in ACCESS aborts the write.
        req = 1'b1; we = 1'b1; mode = 2'b10; addr = 7'h10; wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        req = 1'b0;
        clr = 1'b0;
        #1;
        check_eq("abort ack", {31'd0, ack}, 32'd0);
        check_eq("abort busy", {31'd0, busy}, 32'd0);
        check_eq("abort wr_count", wr_count, 32'd0);
        check_eq("abort rd_count", rd_count, 32'd0);
        @(negedge clk);
        clr = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            check_eq("abort no ack", {31'd0, ack}, 32'd0);
        end
        do_access("rd word 10", 1'b0, 2'b10, 7'h10, 32'd0, 1'b0, 32'd0);
        do_access("rd word 08z", 1'b0, 2'b10, 7'h08, 32'd0, 1'b0, 32'd0);
        check_eq("cnt wr f", wr_count, 32'd0);
        check_eq("cnt rd f", rd_count, 32'd2);

        // Write counter wrap.
        force dut.r_wr_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_wr_count;
        check_eq("wrap preload", wr_count, 32'hFFFF_FFFF);
        do_access("wr wrap", 1'b1, 2'b10, 7'h14, 32'h0BAD_F00D, 1'b0, 32'd0);
        check_eq("wrap wr_count", wr_count, 32'd0);
        check_eq("wrap rd_count", rd_count, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
